id_ex_stage_reg: RTL and testbench

- ID/EX pipeline register of the 5-stage RV32 core, with integrated load-use hazard detection and bubble/flush insertion.
- Sits between decode and execute.
- Its EX_* outputs feed the forwarding unit's EX_Rs1/EX_Rs2 inputs, the ALU operand muxes and the EX/MEM register.
- Also counts inserted bubbles and flushes for performance debug.

---
 rtl/id_ex_stage_reg.sv | 125 ++++++++++++
 tb/tb_id_ex_stage_reg.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register for the 5-stage RV32 core.
// Detects load-use hazards, inserts bubbles on stall or flush, and counts both events.
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic              ID_RegWrite_i,
    input  logic              ID_MemtoReg_i,
    input  logic              ID_MemRead_i,
    input  logic              ID_MemWrite_i,
    input  logic              ID_ALUSrc_i,
    input  logic [1:0]        ID_ALUOp_i,
    input  logic [4:0]        ID_Rs1_i,
    input  logic [4:0]        ID_Rs2_i,
    input  logic [4:0]        ID_Rd_i,
    input  logic [DATA_W-1:0] ID_Data1_i,
    input  logic [DATA_W-1:0] ID_Data2_i,
    input  logic [DATA_W-1:0] ID_Imm_i,
    input  logic [DATA_W-1:0] ID_PC_i,
    input  logic [9:0]        ID_Funct_i,
    output logic              EX_RegWrite_o,
    output logic              EX_MemtoReg_o,
    output logic              EX_MemRead_o,
    output logic              EX_MemWrite_o,
    output logic              EX_ALUSrc_o,
    output logic [1:0]        EX_ALUOp_o,
    output logic [4:0]        EX_Rs1_o,
    output logic [4:0]        EX_Rs2_o,
    output logic [4:0]        EX_Rd_o,
    output logic [DATA_W-1:0] EX_Data1_o,
    output logic [DATA_W-1:0] EX_Data2_o,
    output logic [DATA_W-1:0] EX_Imm_o,
    output logic [DATA_W-1:0] EX_PC_o,
    output logic [9:0]        EX_Funct_o,
    output logic              EX_Valid_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic hazard;
    logic load_bubble;

    // A bubble in EX has EX_Valid_o = 0, so it can never stall the next instruction.
    assign hazard = EX_Valid_o & EX_MemRead_o & (EX_Rd_o != 5'd0) &
                    ((EX_Rd_o == ID_Rs1_i) | (EX_Rd_o == ID_Rs2_i));

    assign stall_o     = hazard & ~flush_i & ~hold_i;
    assign load_bubble = flush_i | hazard;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            EX_RegWrite_o <= 1'b0;
            EX_MemtoReg_o <= 1'b0;
            EX_MemRead_o  <= 1'b0;
            EX_MemWrite_o <= 1'b0;
            EX_ALUSrc_o   <= 1'b0;
            EX_ALUOp_o    <= 2'b00;
            EX_Rs1_o      <= 5'd0;
            EX_Rs2_o      <= 5'd0;
            EX_Rd_o       <= 5'd0;
            EX_Data1_o    <= '0;
            EX_Data2_o    <= '0;
            EX_Imm_o      <= '0;
            EX_PC_o       <= '0;
            EX_Funct_o    <= 10'd0;
            EX_Valid_o    <= 1'b0;
        end else if (!hold_i) begin
            if (load_bubble) begin
                EX_RegWrite_o <= 1'b0;
                EX_MemtoReg_o <= 1'b0;
                EX_MemRead_o  <= 1'b0;
                EX_MemWrite_o <= 1'b0;
                EX_ALUSrc_o   <= 1'b0;
                EX_ALUOp_o    <= 2'b00;
                EX_Rs1_o      <= 5'd0;
                EX_Rs2_o      <= 5'd0;
                EX_Rd_o       <= 5'd0;
                EX_Data1_o    <= '0;
                EX_Data2_o    <= '0;
                EX_Imm_o      <= '0;
                EX_PC_o       <= '0;
                EX_Funct_o    <= 10'd0;
                EX_Valid_o    <= 1'b0;
            end else begin
                EX_RegWrite_o <= ID_RegWrite_i;
                EX_MemtoReg_o <= ID_MemtoReg_i;
                EX_MemRead_o  <= ID_MemRead_i;
                EX_MemWrite_o <= ID_MemWrite_i;
                EX_ALUSrc_o   <= ID_ALUSrc_i;
                EX_ALUOp_o    <= ID_ALUOp_i;
                EX_Rs1_o      <= ID_Rs1_i;
                EX_Rs2_o      <= ID_Rs2_i;
                EX_Rd_o       <= ID_Rd_i;
                EX_Data1_o    <= ID_Data1_i;
                EX_Data2_o    <= ID_Data2_i;
                EX_Imm_o      <= ID_Imm_i;
                EX_PC_o       <= ID_PC_i;
                EX_Funct_o    <= ID_Funct_i;
                EX_Valid_o    <= 1'b1;
            end
        end
    end

    // Flush outranks the hazard, so a squashed load-use bumps only the flush counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else if (!hold_i) begin
            if (flush_i) begin
                if (flush_cnt_o != '1) flush_cnt_o <= flush_cnt_o + CNT_ONE;
            end else if (hazard) begin
                if (stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: vector table fed through a scoreboard queue,
// then counter saturation and asynchronous reset in the middle of a stall.
module tb_id_ex_stage_reg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              hold_i, flush_i;
    logic              ID_RegWrite_i, ID_MemtoReg_i, ID_MemRead_i, ID_MemWrite_i, ID_ALUSrc_i;
    logic [1:0]        ID_ALUOp_i;
    logic [4:0]        ID_Rs1_i, ID_Rs2_i, ID_Rd_i;
    logic [DATA_W-1:0] ID_Data1_i, ID_Data2_i, ID_Imm_i, ID_PC_i;
    logic [9:0]        ID_Funct_i;
    logic              EX_RegWrite_o, EX_MemtoReg_o, EX_MemRead_o, EX_MemWrite_o, EX_ALUSrc_o;
    logic [1:0]        EX_ALUOp_o;
    logic [4:0]        EX_Rs1_o, EX_Rs2_o, EX_Rd_o;
    logic [DATA_W-1:0] EX_Data1_o, EX_Data2_o, EX_Imm_o, EX_PC_o;
    logic [9:0]        EX_Funct_o;
    logic              EX_Valid_o, stall_o;
    logic [CNT_W-1:0]  stall_cnt_o, flush_cnt_o;

    // Counter width reduced so saturation is reachable in a few hundred cycles.
    id_ex_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i), .flush_i(flush_i),
        .ID_RegWrite_i(ID_RegWrite_i), .ID_MemtoReg_i(ID_MemtoReg_i),
        .ID_MemRead_i(ID_MemRead_i), .ID_MemWrite_i(ID_MemWrite_i),
        .ID_ALUSrc_i(ID_ALUSrc_i), .ID_ALUOp_i(ID_ALUOp_i),
        .ID_Rs1_i(ID_Rs1_i), .ID_Rs2_i(ID_Rs2_i), .ID_Rd_i(ID_Rd_i),
        .ID_Data1_i(ID_Data1_i), .ID_Data2_i(ID_Data2_i), .ID_Imm_i(ID_Imm_i),
        .ID_PC_i(ID_PC_i), .ID_Funct_i(ID_Funct_i),
        .EX_RegWrite_o(EX_RegWrite_o), .EX_MemtoReg_o(EX_MemtoReg_o),
        .EX_MemRead_o(EX_MemRead_o), .EX_MemWrite_o(EX_MemWrite_o),
        .EX_ALUSrc_o(EX_ALUSrc_o), .EX_ALUOp_o(EX_ALUOp_o),
        .EX_Rs1_o(EX_Rs1_o), .EX_Rs2_o(EX_Rs2_o), .EX_Rd_o(EX_Rd_o),
        .EX_Data1_o(EX_Data1_o), .EX_Data2_o(EX_Data2_o), .EX_Imm_o(EX_Imm_o),
        .EX_PC_o(EX_PC_o), .EX_Funct_o(EX_Funct_o), .EX_Valid_o(EX_Valid_o),
        .stall_o(stall_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        hold, flush, rw, mr;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1;
        logic        exp_stall, exp_valid, exp_rw, exp_mr;
        logic [4:0]  exp_rs1, exp_rs2, exp_rd;
        logic [31:0] exp_d1;
        logic [7:0]  exp_scnt, exp_fcnt;
    } vec_t;

    vec_t vecs[15];
    vec_t sb_q[$];
    int   pass_count = 0;
    int   total_count = 0;

    // Secondary ID fields are derived from Data1 so one table column describes the instruction.
    function automatic logic [31:0] data2_of(input logic [31:0] d);  return d + 32'h10;            endfunction
    function automatic logic [31:0] imm_of(input logic [31:0] d);    return d ^ 32'h5a5a;          endfunction
    function automatic logic [31:0] pc_of(input logic [31:0] d);     return {d[29:0], 2'b00};      endfunction
    function automatic logic [9:0]  funct_of(input logic [31:0] d);  return d[9:0] ^ 10'h2a5;      endfunction
    function automatic logic [1:0]  aluop_of(input logic [31:0] d);  return d[5:4] ^ d[9:8];       endfunction
    function automatic logic        memwr_of(input logic [31:0] d);  return d[8];                  endfunction

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic driveId(input logic hold, input logic flush, input logic rw, input logic mr,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic [31:0] d1);
        hold_i        = hold;
        flush_i       = flush;
        ID_RegWrite_i = rw;
        ID_MemRead_i  = mr;
        ID_MemtoReg_i = mr;
        ID_ALUSrc_i   = mr;
        ID_MemWrite_i = memwr_of(d1);
        ID_ALUOp_i    = aluop_of(d1);
        ID_Rs1_i      = rs1;
        ID_Rs2_i      = rs2;
        ID_Rd_i       = rd;
        ID_Data1_i    = d1;
        ID_Data2_i    = data2_of(d1);
        ID_Imm_i      = imm_of(d1);
        ID_PC_i       = pc_of(d1);
        ID_Funct_i    = funct_of(d1);
    endtask

    // Drive one vector, check the combinational stall, and queue the post-edge expectation.
    task automatic applyStimulus(input vec_t v);
        driveId(v.hold, v.flush, v.rw, v.mr, v.rs1, v.rs2, v.rd, v.d1);
        #1;
        checkField("stall_o", {31'd0, stall_o}, {31'd0, v.exp_stall});
        sb_q.push_back(v);
    endtask

    task automatic checkOutput();
        vec_t e;
        logic [31:0] d;
        if (sb_q.size() == 0) begin
            checkField("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        d = e.exp_valid ? e.exp_d1 : 32'd0;
        checkField("EX_Valid_o",    {31'd0, EX_Valid_o},    {31'd0, e.exp_valid});
        checkField("EX_RegWrite_o", {31'd0, EX_RegWrite_o}, {31'd0, e.exp_rw});
        checkField("EX_MemRead_o",  {31'd0, EX_MemRead_o},  {31'd0, e.exp_mr});
        checkField("EX_MemtoReg_o", {31'd0, EX_MemtoReg_o}, {31'd0, e.exp_mr});
        checkField("EX_ALUSrc_o",   {31'd0, EX_ALUSrc_o},   {31'd0, e.exp_mr});
        checkField("EX_MemWrite_o", {31'd0, EX_MemWrite_o}, {31'd0, e.exp_valid & memwr_of(d)});
        checkField("EX_ALUOp_o",    {30'd0, EX_ALUOp_o},    {30'd0, e.exp_valid ? aluop_of(d) : 2'b00});
        checkField("EX_Rs1_o",      {27'd0, EX_Rs1_o},      {27'd0, e.exp_rs1});
        checkField("EX_Rs2_o",      {27'd0, EX_Rs2_o},      {27'd0, e.exp_rs2});
        checkField("EX_Rd_o",       {27'd0, EX_Rd_o},       {27'd0, e.exp_rd});
        checkField("EX_Data1_o",    EX_Data1_o,             d);
        checkField("EX_Data2_o",    EX_Data2_o,             e.exp_valid ? data2_of(d) : 32'd0);
        checkField("EX_Imm_o",      EX_Imm_o,               e.exp_valid ? imm_of(d)   : 32'd0);
        checkField("EX_PC_o",       EX_PC_o,                e.exp_valid ? pc_of(d)    : 32'd0);
        checkField("EX_Funct_o",    {22'd0, EX_Funct_o},    {22'd0, e.exp_valid ? funct_of(d) : 10'd0});
        checkField("stall_cnt_o",   {24'd0, stall_cnt_o},   {24'd0, e.exp_scnt});
        checkField("flush_cnt_o",   {24'd0, flush_cnt_o},   {24'd0, e.exp_fcnt});
    endtask

    initial begin
        // hold flush rw mr rs1 rs2 rd d1 | stall valid rw mr rs1 rs2 rd d1 scnt fcnt
        vecs[0]  = '{0,0,1,0, 1, 2, 3,32'h010, 0,1,1,0, 1, 2, 3,32'h010, 0,0}; // add x3,x1,x2
        vecs[1]  = '{0,0,1,1, 1, 0, 5,32'h100, 0,1,1,1, 1, 0, 5,32'h100, 0,0}; // lw x5
        vecs[2]  = '{0,0,1,0, 1, 5, 6,32'h200, 1,0,0,0, 0, 0, 0,32'h000, 1,0}; // use x5 -> bubble
        vecs[3]  = '{0,0,1,0, 1, 5, 6,32'h200, 0,1,1,0, 1, 5, 6,32'h200, 1,0}; // dependent captured
        vecs[4]  = '{0,0,1,1, 2, 0, 0,32'h300, 0,1,1,1, 2, 0, 0,32'h300, 1,0}; // lw x0
        vecs[5]  = '{0,0,1,0, 0, 0, 7,32'h400, 0,1,1,0, 0, 0, 7,32'h400, 1,0}; // x0 never stalls
        vecs[6]  = '{0,0,1,1, 3, 0, 8,32'h500, 0,1,1,1, 3, 0, 8,32'h500, 1,0}; // lw x8
        vecs[7]  = '{0,1,1,0, 8, 8, 9,32'h600, 0,0,0,0, 0, 0, 0,32'h000, 1,1}; // hazard + flush
        vecs[8]  = '{0,0,1,1, 1, 0,10,32'h700, 0,1,1,1, 1, 0,10,32'h700, 1,1}; // lw x10
        vecs[9]  = '{1,1,1,0,10,10,11,32'h800, 0,1,1,1, 1, 0,10,32'h700, 1,1}; // hold + flush
        vecs[10] = '{1,0,1,0,10,10,11,32'h800, 0,1,1,1, 1, 0,10,32'h700, 1,1}; // hold + hazard
        vecs[11] = '{1,1,0,0, 4, 3,12,32'h900, 0,1,1,1, 1, 0,10,32'h700, 1,1}; // hold, new inputs
        vecs[12] = '{0,0,1,0,10,10,11,32'h800, 1,0,0,0, 0, 0, 0,32'h000, 2,1}; // both rs match
        vecs[13] = '{0,0,1,0,10,10,11,32'h800, 0,1,1,0,10,10,11,32'h800, 2,1};
        vecs[14] = '{0,1,1,0, 1, 2,13,32'ha00, 0,0,0,0, 0, 0, 0,32'h000, 2,2}; // plain flush

        rst_i = 1'b0;
        driveId(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 32'd0);
        #12;
        checkField("reset_valid",   {31'd0, EX_Valid_o},    32'd0);
        checkField("reset_regwr",   {31'd0, EX_RegWrite_o}, 32'd0);
        checkField("reset_rd",      {27'd0, EX_Rd_o},       32'd0);
        checkField("reset_data1",   EX_Data1_o,             32'd0);
        checkField("reset_stall",   {31'd0, stall_o},       32'd0);
        checkField("reset_scnt",    {24'd0, stall_cnt_o},   32'd0);
        checkField("reset_fcnt",    {24'd0, flush_cnt_o},   32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(posedge clk_i);
            #1;
            checkOutput();
        end

        // Back-to-back lw x5 / use pairs drive the stall counter into saturation.
        driveId(0, 0, 1, 1, 5'd0, 5'd5, 5'd5, 32'hb00);
        for (int i = 0; i < 256; i++) begin
            @(posedge clk_i);
            #1;
            checkField("sat_stall_on", {31'd0, stall_o}, 32'd1);
            @(posedge clk_i);
            #1;
            checkField("sat_bubble", {31'd0, EX_Valid_o}, 32'd0);
            checkField("sat_scnt", {24'd0, stall_cnt_o}, (i + 3 > 255) ? 32'd255 : 32'(i + 3));
        end

        // Reset mid-stall must clear everything before any further clock edge.
        @(posedge clk_i);
        #1;
        checkField("pre_reset_stall", {31'd0, stall_o}, 32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        checkField("async_stall", {31'd0, stall_o},      32'd0);
        checkField("async_valid", {31'd0, EX_Valid_o},   32'd0);
        checkField("async_mr",    {31'd0, EX_MemRead_o}, 32'd0);
        checkField("async_rd",    {27'd0, EX_Rd_o},      32'd0);
        checkField("async_data1", EX_Data1_o,            32'd0);
        checkField("async_scnt",  {24'd0, stall_cnt_o},  32'd0);
        checkField("async_fcnt",  {24'd0, flush_cnt_o},  32'd0);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
